epp_port: RTL



---
 rtl/epp_port.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/epp_port.sv
// Host-side EPP slave: turns PC address/data cycles into one-hot direction commands,
// a game reset request, and read-back of the game status word and a reject counter.
module epp_port #(
    parameter int RST_PULSE   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        astb,
    input  logic        dstb,
    input  logic        pwr,
    inout  wire  [7:0]  pdb,
    output logic        pwait,
    output logic [3:0]  epp_data,
    output logic        epp_wr,
    output logic        game_rst,
    input  logic [15:0] number
);

    localparam int CNT_W = $clog2(RST_PULSE + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] astb_sync;
    logic [SYNC_STAGES-1:0] dstb_sync;
    logic [SYNC_STAGES-1:0] pwr_sync;
    logic                   astb_s;
    logic                   dstb_s;
    logic                   pwr_s;
    logic                   armed;
    logic [7:0]             addr;
    logic [7:0]             reject_cnt;
    logic [CNT_W-1:0]       rst_cnt;
    logic                   bus_oe;
    logic [7:0]             bus_q;
    logic [7:0]             rd_mux;

    assign astb_s = astb_sync[SYNC_STAGES-1];
    assign dstb_s = dstb_sync[SYNC_STAGES-1];
    assign pwr_s  = pwr_sync[SYNC_STAGES-1];

    assign pdb = bus_oe ? bus_q : 8'bz;

    function automatic logic is_dir(input logic [7:0] v);
        return (v[7:4] == 4'd0) && (v[3:0] != 4'd0) &&
               ((v[3:0] & (v[3:0] - 4'd1)) == 4'd0);
    endfunction

    // Strobes reset to "low" so a strobe held high still has to propagate before arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            astb_sync <= '0;
            dstb_sync <= '0;
            pwr_sync  <= '0;
        end else begin
            astb_sync <= {astb_sync[SYNC_STAGES-2:0], astb};
            dstb_sync <= {dstb_sync[SYNC_STAGES-2:0], dstb};
            pwr_sync  <= {pwr_sync[SYNC_STAGES-2:0], pwr};
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            8'h00:   rd_mux = {4'b0, epp_data};
            8'h01:   rd_mux = number[7:0];
            8'h02:   rd_mux = number[15:8];
            8'h03:   rd_mux = {7'b0, game_rst};
            8'h04:   rd_mux = reject_cnt;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pwait      <= 1'b0;
            bus_oe     <= 1'b0;
            bus_q      <= 8'h00;
            addr       <= 8'h00;
            epp_data   <= 4'b0001;
            epp_wr     <= 1'b0;
            game_rst   <= 1'b0;
            rst_cnt    <= '0;
            reject_cnt <= 8'h00;
            armed      <= 1'b0;
        end else begin
            epp_wr <= 1'b0;
            if (astb_s && dstb_s)
                armed <= 1'b1;

            if (rst_cnt != '0)
                rst_cnt <= rst_cnt - CNT_W'(1);
            else
                game_rst <= 1'b0;

            case (state)
                IDLE: begin
                    // Address strobe wins when the host drops both at once.
                    if (armed && !astb_s) begin
                        pwait <= 1'b1;
                        state <= HOLD;
                        if (pwr_s) begin
                            bus_oe <= 1'b1;
                            bus_q  <= addr;
                        end else begin
                            addr <= pdb;
                        end
                    end else if (armed && !dstb_s) begin
                        pwait <= 1'b1;
                        state <= HOLD;
                        if (pwr_s) begin
                            bus_oe <= 1'b1;
                            bus_q  <= rd_mux;
                        end else begin
                            case (addr)
                                8'h00: begin
                                    if (is_dir(pdb)) begin
                                        epp_data <= pdb[3:0];
                                        epp_wr   <= 1'b1;
                                    end else if (reject_cnt != 8'hFF) begin
                                        reject_cnt <= reject_cnt + 8'd1;
                                    end
                                end
                                8'h03: begin
                                    if (pdb[0]) begin
                                        game_rst <= 1'b1;
                                        rst_cnt  <= CNT_W'(RST_PULSE - 1);
                                    end
                                end
                                8'h04:   reject_cnt <= 8'h00;
                                default: ;
                            endcase
                        end
                    end
                end
                HOLD: begin
                    if (astb_s && dstb_s) begin
                        pwait  <= 1'b0;
                        bus_oe <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
